dmg_link_peer: RTL
==================

Name: dmg_link_peer

Overview:
- Far end of the DMG serial link cable: the partner device exchanging bytes with the CPU's serial port (SB/SC) over SCK/SOUT/SIN.
- Runs as clock follower (DMG drives SCK) or clock driver (peer drives SCK at 8192 Hz equivalent).
- Sits in the bench/system top beside the CPU.
- Gives link-cable exchanges cycle-accurate, deterministic stimulus, with an idle cable returning 0xFF.

Parameters:
- HALF_PERIOD, 256, clk cycles per SCK half-period in driver mode (512-cycle period = 8192 Hz at 4.19 MHz).
- SYNC_STAGES, 2, synchroniser depth for incoming sck_in/sout; legal values 2..3.
- TIMEOUT, 65535, clk cycles without an SCK edge before a started follower transfer is aborted.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- nreset  in  1  asynchronous active-low reset.
- sck_in  in  1  serial clock from DMG; idles high.
- sout  in  1  DMG serial data out.
- sin  out  1  data to DMG serial in.
- sck_out  out  1  peer-generated serial clock.
- sck_oe  out  1  high while peer drives SCK (driver mode, transfer active).
- drive_clk  in  1  1 = driver mode; sampled only in IDLE.
- tx_data  in  8  byte to send.
- tx_load  in  1  one-cycle strobe; latches tx_data and arms a transfer.
- busy  out  1  transfer armed or in progress.
- rx_data  out  8  last received byte.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- rx_abort  out  1  one-cycle pulse on follower timeout.

Behaviour:
- Reset (async, nreset low):
  - state=IDLE, shift register=0xFF, bit counter=0.
  - sin=1, sck_out=1, sck_oe=0, busy=0, rx_data=0x00, rx_valid=0, rx_abort=0.
  - Synchroniser flops preset to 1.
- States: IDLE, ARMED, SHIFT, DONE.
- IDLE:
  - tx_load loads the shift register and latches drive_clk. Next state is ARMED, or SHIFT directly in driver mode.
  - tx_load while not IDLE is ignored; no queueing.
- Follower mode:
  - sck_in passes through SYNC_STAGES flops. A falling/rising edge is detected from the last two stages, giving a fixed SYNC_STAGES+1 cycle latency from pin to action.
  - The first falling edge in ARMED or IDLE moves to SHIFT. In IDLE, the shift register holds 0xFF, so an unarmed peer returns 0xFF.
  - Falling SCK: sin <= shreg[7].
  - Rising SCK: shreg <= {shreg[6:0], sout_sync}, bit counter +1.
  - The 8th rising edge (counter wraps 7->0) goes to DONE.
- Driver mode:
  - sck_out toggles every HALF_PERIOD cycles, starting low.
  - The same drive-on-fall, sample-on-rise rule applies, using the internal edge directly with no sync delay on the clock. sout is still synchronised.
  - After the 8th rising edge, sck_out stays high and sck_oe drops in the same cycle.
- DONE, lasting one cycle:
  - rx_data <= shreg, rx_valid=1, shreg reloaded to 0xFF, sin returns to 1.
  - Next state is IDLE.
- Timeout: in SHIFT in follower mode, a counter clears on every SCK edge. Reaching TIMEOUT gives rx_abort=1 for one cycle, then IDLE. rx_data is unchanged, shreg=0xFF, counter=0.
- busy = (state != IDLE).
- Edges arriving in IDLE with drive_clk=1 are ignored.
- Simultaneous tx_load and a follower falling edge in IDLE: the load wins, and the falling edge outputs tx_data[7] in the same update.
- nreset asserted mid-transfer aborts immediately to reset values, with no rx_valid/rx_abort pulse.
- Glitch handling: an edge is recognised only after a full synchroniser pass. Pulses shorter than one clk may be lost; this is acceptable.

Decomposition:
- Shared package dmg_link_pkg:
  - state enum link_state_t {IDLE, ARMED, SHIFT, DONE}.
  - LINK_BITS=8 and LINK_IDLE_BYTE=8'hFF.
  - Default HALF_PERIOD constant.
- One sub-module: link_edge_sync (SYNC_STAGES synchroniser plus rise/fall pulse outputs). It is instantiated for sck_in and, without edge outputs, for sout.

Test Plan:
- Follower, tx_load 0x5A, DMG clocks 0xC3 at 8192 Hz -> DMG receives 0x5A, rx_data=0xC3, one rx_valid pulse, busy falls after DONE.
- Follower with no tx_load, DMG sends 0x12 -> DMG receives 0xFF, rx_data=0x12.
- Driver mode, HALF_PERIOD=4, tx_load 0xA5, sout tied to sin loopback -> exactly 8 sck_out low pulses of 4 cycles, rx_data=0xA5, sck_oe low afterwards.
- Follower, tx_load 0x81, DMG stops after 3 bits, TIMEOUT=100 -> rx_abort pulse 100 cycles after last edge, rx_valid never asserts, rx_data holds prior value, next transfer with fresh tx_load 0x7E completes correctly.
- nreset pulsed after bit 5 of a transfer -> all outputs at reset values asynchronously; a subsequent full transfer returns correct bytes.
- Second tx_load 0x33 during an active transfer -> ignored; the in-flight byte is sent unchanged.

Source files
------------

// File: rtl/dmg_link_pkg.sv
// Shared types and constants for the DMG link-cable peer.
// Pure definitions; no timing or flow-control behaviour of its own.
package dmg_link_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } link_state_t;

  localparam int         LINK_BITS           = 8;
  localparam logic [7:0] LINK_IDLE_BYTE      = 8'hFF;
  localparam int         DEFAULT_HALF_PERIOD = 256;
  localparam int         DEFAULT_SYNC_STAGES = 2;
  localparam int         DEFAULT_TIMEOUT     = 65535;

endpackage

// File: rtl/link_edge_sync.sv
// Multi-flop synchroniser with optional rise/fall pulses, flops preset high (idle cable level).
// Latency: STAGES clk to q, STAGES+1 clk to acting on an edge pulse; no backpressure.
module link_edge_sync #(
  parameter int STAGES = 2,
  parameter bit EDGES  = 1'b1
) (
  input  logic clk,
  input  logic nreset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

  if (EDGES) begin : g_edges
    // One history flop behind the chain so the edge is seen only after a full sync pass.
    logic hist_q;
    logic hist_d;

    always_comb begin
      hist_d = q;
    end

    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        hist_q <= 1'b1;
      end else begin
        hist_q <= hist_d;
      end
    end

    assign rise = q & ~hist_q;
    assign fall = ~q & hist_q;
  end else begin : g_level_only
    assign rise = 1'b0;
    assign fall = 1'b0;
  end

endmodule

// File: rtl/dmg_link_peer.sv
// Far end of the DMG link cable: shifts one byte per transfer as SCK follower or SCK driver.
// Latency: SYNC_STAGES+1 clk from SCK pin to action; no backpressure, tx_load outside IDLE is dropped.
module dmg_link_peer
  import dmg_link_pkg::*;
#(
  parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       sck_in,
  input  logic       sout,
  output logic       sin,
  output logic       sck_out,
  output logic       sck_oe,
  input  logic       drive_clk,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_abort
);

  localparam int CW = $clog2(LINK_BITS);
  localparam int HW = $clog2(HALF_PERIOD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] LAST_BIT  = CW'(LINK_BITS - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  logic sck_rise;
  logic sck_fall;
  logic sck_lvl_unused;
  logic sout_sync;
  logic sout_rise_unused;
  logic sout_fall_unused;

  link_edge_sync #(
    .STAGES (SYNC_STAGES),
    .EDGES  (1'b1)
  ) u_sck_sync (
    .clk    (clk),
    .nreset (nreset),
    .d      (sck_in),
    .q      (sck_lvl_unused),
    .rise   (sck_rise),
    .fall   (sck_fall)
  );

  link_edge_sync #(
    .STAGES (SYNC_STAGES),
    .EDGES  (1'b0)
  ) u_sout_sync (
    .clk    (clk),
    .nreset (nreset),
    .d      (sout),
    .q      (sout_sync),
    .rise   (sout_rise_unused),
    .fall   (sout_fall_unused)
  );

  link_state_t          state_q,    state_d;
  logic [LINK_BITS-1:0] shreg_q,    shreg_d;
  logic [CW-1:0]        bit_cnt_q,  bit_cnt_d;
  logic [HW-1:0]        half_q,     half_d;
  logic [TW-1:0]        tmo_q,      tmo_d;
  logic                 drv_q,      drv_d;
  logic                 sin_q,      sin_d;
  logic                 sck_out_q,  sck_out_d;
  logic                 sck_oe_q,   sck_oe_d;
  logic [7:0]           rx_data_q,  rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_abort_q, rx_abort_d;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    half_d     = half_q;
    tmo_d      = tmo_q;
    drv_d      = drv_q;
    sin_d      = sin_q;
    sck_out_d  = sck_out_q;
    sck_oe_d   = sck_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_abort_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_load) begin
          shreg_d   = tx_data;
          drv_d     = drive_clk;
          bit_cnt_d = '0;
          tmo_d     = '0;
          if (drive_clk) begin
            // Starting low is the first falling edge, so the MSB goes out now.
            state_d   = SHIFT;
            sck_out_d = 1'b0;
            sck_oe_d  = 1'b1;
            half_d    = '0;
            sin_d     = tx_data[7];
          end else if (sck_fall) begin
            state_d = SHIFT;
            sin_d   = tx_data[7];
          end else begin
            state_d = ARMED;
          end
        end else if (!drive_clk && sck_fall) begin
          // Unarmed: shreg still holds the idle byte, so the DMG reads 0xFF.
          state_d   = SHIFT;
          drv_d     = 1'b0;
          bit_cnt_d = '0;
          tmo_d     = '0;
          sin_d     = shreg_q[LINK_BITS-1];
        end
      end

      ARMED: begin
        if (sck_fall) begin
          state_d = SHIFT;
          tmo_d   = '0;
          sin_d   = shreg_q[LINK_BITS-1];
        end
      end

      SHIFT: begin
        if (drv_q) begin
          if (half_q == HALF_LAST) begin
            half_d    = '0;
            sck_out_d = ~sck_out_q;
            if (sck_out_q) begin
              sin_d = shreg_q[LINK_BITS-1];
            end else begin
              shreg_d   = {shreg_q[LINK_BITS-2:0], sout_sync};
              bit_cnt_d = bit_cnt_q + 1'b1;
              if (bit_cnt_q == LAST_BIT) begin
                state_d  = DONE;
                sck_oe_d = 1'b0;
              end
            end
          end else begin
            half_d = half_q + 1'b1;
          end
        end else begin
          if (sck_fall) begin
            sin_d = shreg_q[LINK_BITS-1];
            tmo_d = '0;
          end else if (sck_rise) begin
            shreg_d   = {shreg_q[LINK_BITS-2:0], sout_sync};
            bit_cnt_d = bit_cnt_q + 1'b1;
            tmo_d     = '0;
            if (bit_cnt_q == LAST_BIT) begin
              state_d = DONE;
            end
          end else if (tmo_q == TMO_LAST) begin
            // DMG stopped clocking mid-byte: drop the partial byte, keep the last good rx_data.
            state_d    = IDLE;
            rx_abort_d = 1'b1;
            shreg_d    = LINK_IDLE_BYTE;
            bit_cnt_d  = '0;
            tmo_d      = '0;
            sin_d      = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end

      DONE: begin
        state_d    = IDLE;
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
        shreg_d    = LINK_IDLE_BYTE;
        bit_cnt_d  = '0;
        sin_d      = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IDLE;
      shreg_q    <= LINK_IDLE_BYTE;
      bit_cnt_q  <= '0;
      half_q     <= '0;
      tmo_q      <= '0;
      drv_q      <= 1'b0;
      sin_q      <= 1'b1;
      sck_out_q  <= 1'b1;
      sck_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_abort_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      half_q     <= half_d;
      tmo_q      <= tmo_d;
      drv_q      <= drv_d;
      sin_q      <= sin_d;
      sck_out_q  <= sck_out_d;
      sck_oe_q   <= sck_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_abort_q <= rx_abort_d;
    end
  end

  assign sin      = sin_q;
  assign sck_out  = sck_out_q;
  assign sck_oe   = sck_oe_q;
  assign busy     = (state_q != IDLE);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_abort = rx_abort_q;

endmodule
